// File: rtl/bsm_pkg.sv
// Shared definitions for the bit-serial multiplier job sequencer:
// FSM state encoding and a constant-evaluable clog2 helper.
package bsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_serial_mul.sv
// Serial-parallel multiplier: a held in parallel, x fed LSB first, one product bit per cycle
// on y (combinational with x_bit). SIGNED sign-extends a; x sign extension is done by the feeder.
module bit_serial_mul #(
  parameter int W      = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic         x_bit,
  output logic         y
);

  // acc_r holds floor(partial_product / 2^k); W+2 signed bits cover both operand modes
  logic signed [W+1:0] acc_r;
  logic signed [W+1:0] addend_s;
  logic signed [W+1:0] sum_s;

  // Add the selected multiplicand to the running sum and expose its LSB
  always_comb begin
    addend_s = '0;
    if (x_bit) begin
      addend_s = SIGNED ? {{2{a[W-1]}}, a} : {2'b00, a};
    end else begin
      addend_s = '0;
    end
    sum_s = acc_r + addend_s;
    y     = sum_s[0];
  end

  // Accumulator register, cleared by the synchronous reset between jobs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else begin
      acc_r <= sum_s >>> 1;
    end
  end

endmodule

// File: rtl/bit_serial_mul_seq.sv
// Job sequencer for bit_serial_mul: accepts {a,x}, clears the multiplier, streams x
// LSB first (then pads) for 2W cycles and collects the serial product into out_p.
module bit_serial_mul_seq
  import bsm_pkg::*;
#(
  parameter int W      = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_x,
  output logic           mul_rst_n,
  output logic [W-1:0]   mul_a,
  output logic           mul_x_bit,
  input  logic           mul_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p
);

  localparam int            CW       = clog2(2 * W);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * W - 1);

  state_t         state_r;
  state_t         state_s;
  logic [CW-1:0]  cnt_r;
  logic [W-1:0]   x_sh_r;
  logic           load_s;
  logic           pad_s;
  logic           last_s;

  // Handshake and next-state decode
  always_comb begin
    in_ready = 1'b0;
    state_s  = state_r;
    case (state_r)
      ST_IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_s = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        in_ready = rst_n & out_ready;
        if (out_ready && in_valid) begin
          state_s = ST_CLEAR;
        end else if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Shift fill keeps replicating the sign bit once the real x bits are exhausted
  always_comb begin
    load_s = in_valid & in_ready;
    pad_s  = SIGNED ? x_sh_r[W-1] : 1'b0;
    last_s = (cnt_r == CNT_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: operand capture, x serialisation, product capture and registered handshakes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      x_sh_r    <= '0;
      mul_rst_n <= 1'b0;
      mul_a     <= '0;
      mul_x_bit <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      mul_rst_n <= (state_s != ST_CLEAR);
      out_valid <= (state_s == ST_DONE);
      if (load_s) begin
        mul_a  <= in_a;
        x_sh_r <= in_x;
      end
      case (state_r)
        ST_CLEAR: begin
          mul_x_bit <= x_sh_r[0];
          x_sh_r    <= {pad_s, x_sh_r[W-1:1]};
          cnt_r     <= '0;
        end
        ST_RUN: begin
          out_p[cnt_r] <= mul_y;
          mul_x_bit    <= x_sh_r[0];
          x_sh_r       <= {pad_s, x_sh_r[W-1:1]};
          cnt_r        <= last_s ? '0 : cnt_r + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
